// File: rtl/switch_conditioner_if.sv
// Switch conditioner bus: raw switch levels in, debounced value and strobes out.
interface switch_conditioner_if #(
  parameter int unsigned WIDTH = 2
) ();

  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] y_out;
  logic             y_change;
  logic             step;
  logic             busy;

  modport master (
    output sw_raw,
    input  y_out,
    input  y_change,
    input  step,
    input  busy
  );

  modport slave (
    input  sw_raw,
    output y_out,
    output y_change,
    output step,
    output busy
  );

endinterface

// File: rtl/switch_conditioner.sv
// switch_conditioner: synchronises and debounces the slide switches and emits
// one step strobe per sequencer advance.
// Optional feature macro SWITCH_TIMEOUT_STEP_EN: also strobe step after
// TICK_CYCLES cycles without an accepted change.
module switch_conditioner #(
  parameter int unsigned WIDTH           = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned TICK_CYCLES     = 100000000
) (
  input logic                 clk,
  input logic                 rst,
  switch_conditioner_if.slave bus
);

  localparam int unsigned     CNT_W     = 32;
  localparam logic [CNT_W-1:0] DCNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reject illegal parameterisations at elaboration.
  if (DEBOUNCE_CYCLES < 1 || TICK_CYCLES < 2) begin : g_bad_params
    $error("switch_conditioner: DEBOUNCE_CYCLES must be >= 1 and TICK_CYCLES >= 2");
  end

  typedef enum logic {
    STABLE = 1'b0,
    SETTLE = 1'b1
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] cand_n;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] y_n;
  logic [CNT_W-1:0] dcnt;
  logic [CNT_W-1:0] dcnt_n;
  logic             chg_n;
  logic             step_n;
  logic             chg_q;
  logic             step_q;
  logic             busy_q;

  // Two-flop synchroniser for the asynchronous switch levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= bus.sw_raw;
      s2 <= s1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= STABLE;
    end else begin
      state <= state_n;
    end
  end

  // Debounce next-state: bounce-back beats candidate switch beats acceptance.
  always_comb begin
    state_n = state;
    cand_n  = cand;
    dcnt_n  = dcnt;
    y_n     = y_q;
    chg_n   = 1'b0;
    case (state)
      STABLE: begin
        if (s2 != y_q) begin
          cand_n  = s2;
          dcnt_n  = '0;
          state_n = SETTLE;
        end
      end
      SETTLE: begin
        if (s2 == y_q) begin
          dcnt_n  = '0;
          state_n = STABLE;
        end else if (s2 != cand) begin
          cand_n = s2;
          dcnt_n = '0;
        end else if (dcnt == DCNT_LAST) begin
          y_n     = cand;
          chg_n   = 1'b1;
          dcnt_n  = '0;
          state_n = STABLE;
        end else begin
          dcnt_n = dcnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = STABLE;
      end
    endcase
  end

`ifdef SWITCH_TIMEOUT_STEP_EN
  localparam logic [CNT_W-1:0] TCNT_LAST = CNT_W'(TICK_CYCLES - 1);

  logic [CNT_W-1:0] tcnt;
  logic [CNT_W-1:0] tcnt_n;
  logic             tick_c;

  // Idle timer: runs in STABLE, frozen in SETTLE, cleared by an accept.
  always_comb begin
    tcnt_n = tcnt;
    tick_c = 1'b0;
    if (chg_n) begin
      tcnt_n = '0;
    end else if (state == STABLE) begin
      if (tcnt == TCNT_LAST) begin
        tick_c = 1'b1;
        tcnt_n = '0;
      end else begin
        tcnt_n = tcnt + CNT_W'(1);
      end
    end
  end

  // Idle timer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt_n;
    end
  end

  assign step_n = chg_n | tick_c;
`else
  assign step_n = chg_n;
`endif

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand   <= '0;
      dcnt   <= '0;
      y_q    <= '0;
      chg_q  <= 1'b0;
      step_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      cand   <= cand_n;
      dcnt   <= dcnt_n;
      y_q    <= y_n;
      chg_q  <= chg_n;
      step_q <= step_n;
      busy_q <= (state_n == SETTLE);
    end
  end

  assign bus.y_out    = y_q;
  assign bus.y_change = chg_q;
  assign bus.step     = step_q;
  assign bus.busy     = busy_q;

endmodule

// File: doc/switch_conditioner.md
# switch_conditioner

- Upstream input stage for the microcoded state sequencer.
- Takes the raw 2-bit slide-switch input, synchronises it, debounces it and presents a clean stable value `y_out`.
- Emits one `step` strobe per sequencer advance: on every accepted input change, and (optionally) after a fixed period with no change.
- The sequencer consumes `y_out` and advances exactly once per `step`.

## Interface
Parameters:
- `WIDTH`, default 2: width of the switch bus.
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles required to accept a new value. Legal range ≥1.
- `TICK_CYCLES`, default 100000000: idle period before a timeout step. Legal range ≥2.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1: system clock; all logic on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `sw_raw`  in  WIDTH: asynchronous switch levels.
- `y_out`  out  WIDTH: debounced, registered switch value.
- `y_change`  out  1: one-cycle pulse, coincident with the cycle `y_out` takes a new value.
- `step`  out  1: one-cycle advance strobe for the sequencer.
- `busy`  out  1: high while a candidate value is settling.

## Operation
- **Synchroniser.** Two flops, `sw_raw → s1 → s2`. All decisions use `s2` only.
- **FSM, state STABLE.**
  - If `s2 != y_out`: `cand <= s2`, `dcnt <= 0`, go to SETTLE.
  - Otherwise stay in STABLE.
- **FSM, state SETTLE.** Checks are evaluated in priority order:
  1. `s2 == y_out`: bounce back; return to STABLE. No pulse, `y_out` unchanged, `dcnt <= 0`.
  2. `s2 != cand`: `cand <= s2`, `dcnt <= 0`; stay in SETTLE.
  3. `dcnt == DEBOUNCE_CYCLES-1`: accept. `y_out <= cand`, pulse `y_change` and `step`, `tcnt <= 0`, go to STABLE.
  4. Otherwise `dcnt <= dcnt+1`.
- **`busy`** = (state == SETTLE), decoded from the registered state.
- **Counters.** `dcnt` and `tcnt` are 32-bit unsigned. Neither can exceed its compare value, so neither wraps.
- **Reset values.**
  - State STABLE.
  - `s1`, `s2`, `cand`, `y_out` = 0.
  - `dcnt`, `tcnt` = 0.
  - `y_change`, `step`, `busy` = 0.
- **After reset release.** A non-zero switch setting is treated as a normal change: it settles and produces `y_change` and `step`.
- **Reset mid-settle.** Discards the candidate. No pulse is produced for it.

## Timing
- **Acceptance latency.** Suppose `sw_raw` changes and stays constant, and the first edge that samples it into `s1` is E0. Then:
  - `s2` updates at E1.
  - SETTLE is entered at E2.
  - `y_out`, `y_change` and `step` update at edge E0+DEBOUNCE_CYCLES+2.
- **Pulse width.** `y_change` and `step` are registered and high for exactly one cycle. They are never high in consecutive cycles from the same event.
- **Back-to-back changes.** Minimum spacing between two `y_change` pulses is DEBOUNCE_CYCLES+1 cycles.
- **Glitch rejection.** A glitch on `s2` shorter than DEBOUNCE_CYCLES cycles never reaches `y_out`.
- **Consumer handshake.** None beyond the strobe. The sequencer must sample `y_out` in the same cycle as `step`; `y_out` is guaranteed stable in that cycle.

## Configuration
- **Macro `SWITCH_TIMEOUT_STEP_EN` defined.**
  - `tcnt` increments each cycle in STABLE and holds (frozen) in SETTLE.
  - When `tcnt == TICK_CYCLES-1` in STABLE: pulse `step` (not `y_change`), `tcnt <= 0`.
  - If an accept and a timeout land in the same cycle, the accept wins: one `step` pulse, `tcnt <= 0`.
- **Macro not defined.**
  - `tcnt` logic is absent.
  - `step` is identical to `y_change`.
  - `TICK_CYCLES` is ignored.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and TICK_CYCLES=20.
1. **Reset.** Assert `rst` 3 cycles with `sw_raw=2'b00` → all outputs 0, `busy=0`; no `step` for 19 cycles after release (macro off: never).
2. **Clean change.** `sw_raw` 00→10 held steady → `y_out=2'b10`, `y_change=step=1` for one cycle exactly 6 edges after the sampling edge; `busy` high for the 4 cycles before.
3. **Glitch.** `sw_raw` 00→01 for 3 cycles then back to 00 → `y_out` stays 00, no pulse, `busy` returns to 0.
4. **Candidate switch mid-settle.** 00→01 for 2 cycles, then →11 held → single `y_change`, `y_out=2'b11`, never 01.
5. **Timeout (macro on).** Hold `sw_raw` constant 60 cycles after settling → `step` every 20 cycles, `y_change` stays 0. Then apply a change whose accept coincides with `tcnt=19` → exactly one `step` pulse.
6. **Reset mid-settle.** `rst` asserted while `busy=1` → `busy=0` and `y_out=0` next cycle, no pulse. The held non-zero input is re-accepted 6 edges after release.
